// File: rtl/uart_tx_feeder_pkg.sv
// Shared widths and timing constants for the UART TX feeder and its serializer.
// Keeping them in one place makes the feeder byte width and the serializer DBIT agree.
package uart_tx_feeder_pkg;

  localparam int UTF_DATA_W  = 8;
  localparam int UTF_ADDR_W  = 4;
  localparam int UTF_SB_TICK = 16;
  localparam int UTF_DEPTH   = 1 << UTF_ADDR_W;

  // Next FIFO occupancy for one push/pop combination; push and pop together leave it unchanged.
  function automatic logic [UTF_ADDR_W:0] utf_next_count(input logic [UTF_ADDR_W:0] count,
                                                         input logic push,
                                                         input logic pop);
    logic [UTF_ADDR_W:0] result;
    result = count;
    if (push && !pop) result = count + (UTF_ADDR_W + 1)'(1);
    if (pop && !push) result = count - (UTF_ADDR_W + 1)'(1);
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// Synchronous fall-through FIFO: head is visible combinationally at mem[rd_ptr].
// full/empty come from the registered count; a write while full is dropped and flagged.
module sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_W = UTF_DATA_W,
  parameter int ADDR_W = UTF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  // A same-cycle pop never frees room for the write; acceptance looks only at registered full.
  assign w_push  = i_wr_en && !w_full;
  assign w_pop   = i_rd_en && !w_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      if (ADDR_W == UTF_ADDR_W) begin
        r_count <= utf_next_count(r_count, w_push, w_pop);
      end else if (w_push && !w_pop) begin
        r_count <= r_count + (ADDR_W + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (ADDR_W + 1)'(1);
      end
      r_overflow <= i_wr_en && w_full;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to the UART TX serializer.
// state  | meaning
// IDLE   | nothing in flight; pops the FIFO head as soon as it is non-empty
// START  | tx_start high for this single cycle, tx_din holds the popped byte
// WAIT   | frame on the line; tx_din held until the serializer's tx_done_tick
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_W = UTF_DATA_W,
  parameter int ADDR_W = UTF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_tx_din,
  output logic              o_tx_start,
  input  logic              i_tx_done_tick
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e            r_state;
  logic [DATA_W-1:0] r_tx_din;
  logic              r_tx_start;
  logic              r_busy;

  logic [DATA_W-1:0] w_head;
  logic              w_empty;
  logic              w_pop;

  // The only pop point is IDLE->START, so at most one byte is ever in flight.
  assign w_pop = (r_state == S_IDLE) && !w_empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_head),
    .o_full     (o_full),
    .o_empty    (w_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_tx_din   <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_tx_din   <= w_head;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_tx_done_tick) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_empty    = w_empty;
  assign o_busy     = r_busy;
  assign o_tx_din   = r_tx_din;
  assign o_tx_start = r_tx_start;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a behavioural serializer drives tx_done_tick and a serial line,
// and a line monitor decodes the frames that actually left the block.
module tb_uart_tx_feeder;

  localparam int BIT_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       spur = 1'b0;
  logic       full, empty, overflow, busy, tx_start, tx_done_tick;
  logic [4:0] count;
  logic [7:0] tx_din;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_tx_feeder dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_en        (wr_en),
    .i_wr_data      (wr_data),
    .o_full         (full),
    .o_empty        (empty),
    .o_count        (count),
    .o_overflow     (overflow),
    .o_busy         (busy),
    .o_tx_din       (tx_din),
    .o_tx_start     (tx_start),
    .i_tx_done_tick (tx_done_tick)
  );

  // Behavioural serializer: 10-bit frame, BIT_CYC clocks per bit, done pulse after the stop bit.
  logic       ser_act;
  logic [9:0] ser_sh;
  int         ser_bits;
  int         ser_tick;
  logic       line;
  logic       done_m;

  assign tx_done_tick = done_m | spur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_act  <= 1'b0;
      ser_sh   <= 10'h3FF;
      ser_bits <= 0;
      ser_tick <= 0;
      line     <= 1'b1;
      done_m   <= 1'b0;
    end else begin
      done_m <= 1'b0;
      if (!ser_act) begin
        if (tx_start) begin
          ser_act  <= 1'b1;
          ser_sh   <= {1'b1, tx_din, 1'b0};
          line     <= 1'b0;
          ser_bits <= 10;
          ser_tick <= BIT_CYC - 1;
        end
      end else if (ser_tick > 0) begin
        ser_tick <= ser_tick - 1;
      end else if (ser_bits > 1) begin
        ser_bits <= ser_bits - 1;
        ser_sh   <= {1'b1, ser_sh[9:1]};
        line     <= ser_sh[1];
        ser_tick <= BIT_CYC - 1;
      end else begin
        ser_act <= 1'b0;
        line    <= 1'b1;
        done_m  <= 1'b1;
      end
    end
  end

  int n_start = 0;
  int n_viol = 0;
  always @(posedge clk) begin
    if (rst_n && tx_start) begin
      n_start++;
      if (ser_act) n_viol++;
    end
  end

  // Line monitor: samples mid-bit, keeps decoded bytes and the last raw frame (bit 0 = start).
  logic [7:0] byte_q[$];
  logic [9:0] mon_frame = 10'h000;
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (line == 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        mon_frame[0] = 1'b0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % BIT_CYC == BIT_CYC / 2) begin
        mon_frame[mon_cnt / BIT_CYC] = line;
        if (mon_cnt / BIT_CYC == 9) begin
          byte_q.push_back(mon_frame[8:1]);
          mon_act = 1'b0;
        end
      end
    end
  end

  int g_base_q = 0;
  int g_base_s = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int target, input string name);
    int k;
    k = 0;
    while (byte_q.size() < target && k < 3000) begin
      tick();
      k++;
    end
    total++;
    if (byte_q.size() < target) begin
      bad++;
      $display("FAIL %s_rx_timeout got=%0d bytes exp=%0d", name, byte_q.size(), target);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy !== 1'b0 || empty !== 1'b1 || ser_act !== 1'b0) && k < 3000) begin
      tick();
      k++;
    end
    total++;
    if (busy !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL %s_idle_timeout busy=%b empty=%b exp busy=0 empty=1", name, busy, empty);
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (tx_done_tick !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    total++;
    if (tx_done_tick !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_timeout got=%b exp=1", name, tx_done_tick);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({empty, full, overflow, busy, tx_start} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags got e/f/o/b/s=%b exp=10000", {empty, full, overflow, busy, tx_start});
    end
    total++;
    if (count !== 5'd0 || tx_din !== 8'h00) begin
      bad++;
      $display("FAIL reset_regs got count=%0d din=%h exp 0 00", count, tx_din);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int bq, bs;
    bq = byte_q.size();
    bs = n_start;
    wr_en = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    total++;
    if (count !== 5'd1 || tx_start !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_edge0 got count=%0d start=%b busy=%b exp 1 0 0", count, tx_start, busy);
    end
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_din !== 8'hA5 || busy !== 1'b1 || count !== 5'd0) begin
      bad++;
      $display("FAIL single_start got start=%b din=%h busy=%b count=%0d exp 1 a5 1 0", tx_start, tx_din, busy, count);
    end
    tick();
    total++;
    if (tx_start !== 1'b0 || tx_din !== 8'hA5) begin
      bad++;
      $display("FAIL single_pulse got start=%b din=%h exp 0 a5", tx_start, tx_din);
    end
    wait_done("single");
    total++;
    if (busy !== 1'b1 || tx_din !== 8'hA5) begin
      bad++;
      $display("FAIL single_wait_hold got busy=%b din=%h exp 1 a5", busy, tx_din);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy_fall got=%b exp=0", busy);
    end
    repeat (3) tick();
    total++;
    if (byte_q.size() != bq + 1 || mon_frame !== 10'b1101001010) begin
      bad++;
      $display("FAIL single_line got bytes=%0d frame=%b exp %0d 1101001010", byte_q.size() - bq, mon_frame, 1);
    end
    total++;
    if (n_start - bs != 1) begin
      bad++;
      $display("FAIL single_starts got=%0d exp=1", n_start - bs);
    end
  endtask

  task automatic test_burst();
    g_base_q = byte_q.size();
    g_base_s = n_start;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    total++;
    if (count !== 5'd15 || full !== 1'b0 || tx_din !== 8'h00 || busy !== 1'b1) begin
      bad++;
      $display("FAIL burst_16 got count=%0d full=%b din=%h busy=%b exp 15 0 00 1", count, full, tx_din, busy);
    end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    wr_data = 8'h10;
    tick();
    total++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_fill got count=%0d full=%b ovf=%b exp 16 1 0", count, full, overflow);
    end
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    total++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      bad++;
      $display("FAIL ovf_pulse got ovf=%b count=%0d exp 1 16", overflow, count);
    end
    tick();
    total++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      bad++;
      $display("FAIL ovf_clear got ovf=%b count=%0d exp 0 16", overflow, count);
    end
  endtask

  task automatic test_back_to_back();
    int ee_seen;
    wait_done("b2b");
    tick();
    total++;
    if (tx_start !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap got start=%b busy=%b exp 0 0", tx_start, busy);
    end
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_din !== 8'h01 || count !== 5'd15) begin
      bad++;
      $display("FAIL b2b_start got start=%b din=%h count=%0d exp 1 01 15", tx_start, tx_din, count);
    end
    wait_rx(g_base_q + 17, "b2b");
    ee_seen = 0;
    for (int i = 0; i < 17; i++) begin
      if (g_base_q + i < byte_q.size()) begin
        if (byte_q[g_base_q + i] == 8'hEE) ee_seen++;
        total++;
        if (byte_q[g_base_q + i] !== 8'(i)) begin
          bad++;
          $display("FAIL b2b_order[%0d] got=%h exp=%h", i, byte_q[g_base_q + i], 8'(i));
        end
      end
    end
    wait_idle("b2b");
    total++;
    if (n_start - g_base_s != 17 || ee_seen != 0 || byte_q.size() != g_base_q + 17) begin
      bad++;
      $display("FAIL b2b_totals got starts=%0d ee=%0d bytes=%0d exp 17 0 17", n_start - g_base_s, ee_seen, byte_q.size() - g_base_q);
    end
  endtask

  task automatic test_same_cycle_pop();
    int bq;
    bq = byte_q.size();
    wr_en = 1'b1;
    wr_data = 8'hB1;
    tick();
    total++;
    if (count !== 5'd1 || empty !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL pushpop_pre got count=%0d empty=%b busy=%b exp 1 0 0", count, empty, busy);
    end
    wr_data = 8'hB2;
    tick();
    wr_en = 1'b0;
    total++;
    if (count !== 5'd1 || empty !== 1'b0 || tx_start !== 1'b1 || tx_din !== 8'hB1) begin
      bad++;
      $display("FAIL pushpop_edge got count=%0d empty=%b start=%b din=%h exp 1 0 1 b1", count, empty, tx_start, tx_din);
    end
    wait_rx(bq + 2, "pushpop");
    total++;
    if (byte_q.size() < bq + 2 || byte_q[bq] !== 8'hB1 || byte_q[bq + 1] !== 8'hB2) begin
      bad++;
      $display("FAIL pushpop_order got %0d bytes, exp b1 then b2", byte_q.size() - bq);
    end
    wait_idle("pushpop");
  endtask

  task automatic test_reset_mid();
    int bq, bs;
    bq = byte_q.size();
    bs = n_start;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    total++;
    if (count !== 5'd5) begin
      bad++;
      $display("FAIL rstmid_queued got count=%0d exp 5", count);
    end
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (count !== 5'd0 || empty !== 1'b1 || busy !== 1'b0 || tx_start !== 1'b0 || tx_din !== 8'h00 || full !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async got count=%0d empty=%b busy=%b start=%b din=%h exp 0 1 0 0 00", count, empty, busy, tx_start, tx_din);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (300) tick();
    total++;
    if (byte_q.size() != bq || n_start != bs + 1 || busy !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_residual got bytes=%0d starts=%0d busy=%b empty=%b exp 0 1 0 1", byte_q.size() - bq, n_start - bs, busy, empty);
    end
  endtask

  task automatic test_spurious_done();
    int bq, bs;
    bq = byte_q.size();
    bs = n_start;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    total++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL spur_idle got busy=%b start=%b count=%0d exp 0 0 0", busy, tx_start, count);
    end
    wr_en = 1'b1;
    wr_data = 8'hD7;
    tick();
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    total++;
    if (busy !== 1'b1 || tx_start !== 1'b0 || count !== 5'd1 || tx_din !== 8'hD7) begin
      bad++;
      $display("FAIL spur_start got busy=%b start=%b count=%0d din=%h exp 1 0 1 d7", busy, tx_start, count, tx_din);
    end
    repeat (3) tick();
    total++;
    if (busy !== 1'b1 || count !== 5'd1 || n_start - bs != 1) begin
      bad++;
      $display("FAIL spur_nopop got busy=%b count=%0d starts=%0d exp 1 1 1", busy, count, n_start - bs);
    end
    wait_rx(bq + 2, "spur");
    total++;
    if (byte_q.size() < bq + 2 || byte_q[bq] !== 8'hD7 || byte_q[bq + 1] !== 8'h3C) begin
      bad++;
      $display("FAIL spur_order got %0d bytes, exp d7 then 3c", byte_q.size() - bq);
    end
    wait_idle("spur");
    total++;
    if (n_start - bs != 2 || n_viol != 0) begin
      bad++;
      $display("FAIL spur_totals got starts=%0d overlaps=%0d exp 2 0", n_start - bs, n_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_back_to_back();
    test_same_cycle_pop();
    test_reset_mid();
    test_spurious_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
